// File: rtl/router_tx_fifo_nsyn.sv
`default_nettype none
// ============================================================================
// Module      : router_tx_fifo_nsyn
// Description : Frame FIFO (WISHBONE write side) feeding an N-bit-parallel
//               serializer that shifts frames out LSB-beat first.
// Revision    : 1.0 - initial release
// ============================================================================
module router_tx_fifo_nsyn #(
    parameter int pFrameBits    = 128,
    parameter int pBitsParallel = 4,
    parameter int pDepthLog2    = 3,
    parameter int pClkDiv       = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cs_i,
    input  logic                     cyc_i,
    input  logic                     stb_i,
    input  logic                     we_i,
    output logic                     ack_o,
    input  logic [pFrameBits-1:0]    dat_i,
    input  logic                     cts_i,
    output logic [pBitsParallel-1:0] txd_o,
    output logic                     sync_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [pDepthLog2:0]      level_o,
    output logic                     busy_o
);

    localparam int c_BEATS  = pFrameBits / pBitsParallel;
    localparam int c_BEAT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_PS_W   = $clog2(pClkDiv + 1);
    localparam int c_DEPTH  = 2 ** pDepthLog2;

    localparam logic [c_BEAT_W-1:0]   c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);
    localparam logic [c_BEAT_W-1:0]   c_BEAT_ONE  = c_BEAT_W'(1);
    localparam logic [c_PS_W-1:0]     c_PS_LAST   = c_PS_W'(pClkDiv - 1);
    localparam logic [c_PS_W-1:0]     c_PS_ONE    = c_PS_W'(1);
    localparam logic [pDepthLog2-1:0] c_PTR_ONE   = pDepthLog2'(1);
    localparam logic [pDepthLog2:0]   c_LVL_ONE   = (pDepthLog2 + 1)'(1);
    localparam logic [pDepthLog2:0]   c_LVL_FULL  = (pDepthLog2 + 1)'(c_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  r_state;
    logic [pFrameBits-1:0]   r_mem [c_DEPTH];
    logic [pDepthLog2-1:0]   r_wr_ptr;
    logic [pDepthLog2-1:0]   r_rd_ptr;
    logic [pDepthLog2:0]     r_level;
    logic                    r_empty;
    logic                    r_full;
    logic [c_PS_W-1:0]       r_ps;
    logic [c_BEAT_W-1:0]     r_beat;
    logic [pFrameBits-1:0]   r_shift;
    logic                    r_sync;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_tick;
    logic                    w_frame_end;
    logic [pDepthLog2:0]     w_level_nxt;

    assign ack_o       = cs_i & cyc_i & stb_i & (~we_i | ~r_full);
    assign w_push      = ack_o & we_i;
    assign w_tick      = (r_ps == c_PS_LAST);
    assign w_frame_end = (r_state == ST_IDLE) | (r_beat == c_LAST_BEAT);
    // Pop decision uses the registered empty flag, so a fresh push is seen one cycle later.
    assign w_pop       = w_tick & w_frame_end & ~r_empty & cts_i;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_LVL_ONE;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - c_LVL_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_level <= w_level_nxt;
            r_empty <= (w_level_nxt == '0);
            r_full  <= (w_level_nxt == c_LVL_FULL);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ps    <= '0;
            r_beat  <= '0;
            r_shift <= '1;
            r_sync  <= 1'b0;
        end else begin
            r_ps   <= w_tick ? '0 : r_ps + c_PS_ONE;
            r_sync <= 1'b0;
            if (w_tick) begin
                if (w_pop) begin
                    r_state <= ST_SHIFT;
                    r_shift <= r_mem[r_rd_ptr];
                    r_beat  <= '0;
                    r_sync  <= 1'b1;
                end else if (r_state == ST_SHIFT) begin
                    if (r_beat == c_LAST_BEAT) begin
                        r_state <= ST_IDLE;
                        r_shift <= '1;
                    end else begin
                        r_shift <= {{pBitsParallel{1'b1}}, r_shift[pFrameBits-1:pBitsParallel]};
                        r_beat  <= r_beat + c_BEAT_ONE;
                    end
                end
            end
        end
    end

    assign txd_o   = r_shift[pBitsParallel-1:0];
    assign sync_o  = r_sync;
    assign empty_o = r_empty;
    assign full_o  = r_full;
    assign level_o = r_level;
    assign busy_o  = (r_state == ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_router_tx_fifo_nsyn.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_tx_fifo_nsyn
// Description : Bench for router_tx_fifo_nsyn; one instance at one beat per
//               clock and one at three clocks per beat, each with its own model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_tx_fifo_nsyn;

    localparam int FB    = 128;
    localparam int BP    = 4;
    localparam int DL    = 3;
    localparam int BEATS = FB / BP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    cs, cyc, stb, we;
    logic [FB-1:0] dat;
    logic          cts;

    logic          ack   [2];
    logic          sync  [2];
    logic          empty [2];
    logic          full  [2];
    logic          busy  [2];
    logic [BP-1:0] txd   [2];
    logic [DL:0]   lvl   [2];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int DIV = (gi == 0) ? 1 : 3;

        router_tx_fifo_nsyn #(
            .pFrameBits(FB), .pBitsParallel(BP), .pDepthLog2(DL), .pClkDiv(DIV)
        ) u_dut (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .cs_i   (cs[gi]),
            .cyc_i  (cyc[gi]),
            .stb_i  (stb[gi]),
            .we_i   (we[gi]),
            .ack_o  (ack[gi]),
            .dat_i  (dat),
            .cts_i  (cts),
            .txd_o  (txd[gi]),
            .sync_o (sync[gi]),
            .empty_o(empty[gi]),
            .full_o (full[gi]),
            .level_o(lvl[gi]),
            .busy_o (busy[gi])
        );

        // Reference: a queue of pending frames plus the frame on the wire and its beat index.
        logic [FB-1:0] q [$];
        logic [FB-1:0] frm;
        int            ps   = 0;
        int            beat = 0;
        int            sz0;
        bit            act  = 0;
        bit            ld   = 0;
        bit            tick;

        always @(posedge clk) begin
            if (!rst_n) begin
                q.delete();
                act  = 0;
                ps   = 0;
                beat = 0;
                ld   = 0;
            end else begin
                sz0  = q.size();
                tick = (ps == DIV - 1);
                ps   = tick ? 0 : ps + 1;
                ld   = 0;
                if (tick) begin
                    if (!act || beat == BEATS - 1) begin
                        if (sz0 > 0 && cts) begin
                            frm  = q.pop_front();
                            beat = 0;
                            act  = 1;
                            ld   = 1;
                        end else begin
                            act = 0;
                        end
                    end else begin
                        beat++;
                    end
                end
                if (cs[gi] && cyc[gi] && stb[gi] && we[gi] && sz0 < 8) begin
                    q.push_back(dat);
                end
            end
            #1;
            chk($sformatf("d%0d_txd", gi),   txd[gi],   act ? frm[beat*BP +: BP] : 4'hF);
            chk($sformatf("d%0d_sync", gi),  sync[gi],  ld);
            chk($sformatf("d%0d_busy", gi),  busy[gi],  act);
            chk($sformatf("d%0d_level", gi), lvl[gi],   q.size());
            chk($sformatf("d%0d_empty", gi), empty[gi], q.size() == 0);
            chk($sformatf("d%0d_full", gi),  full[gi],  q.size() == 8);
            chk($sformatf("d%0d_ack", gi),   ack[gi],
                cs[gi] & cyc[gi] & stb[gi] & (~we[gi] | (q.size() < 8)));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_idle();
        cs  = '0;
        cyc = '0;
        stb = '0;
        we  = '0;
    endtask

    // Holds the write on each instance until it is acknowledged there.
    task automatic wb_write(input logic [FB-1:0] data);
        logic [1:0] pend;
        logic [1:0] hit;
        int         n;
        pend = 2'b11;
        n    = 0;
        dat  = data;
        cs   = 2'b11;
        cyc  = 2'b11;
        stb  = 2'b11;
        we   = 2'b11;
        while (pend != 2'b00 && n < 1000) begin
            #1;
            hit = pend & {ack[1], ack[0]};
            @(negedge clk);
            pend = pend & ~hit;
            stb  = stb & ~hit;
            n++;
        end
        chk("wr_timeout", pend, 2'b00);
        bus_idle();
    endtask

    task automatic busy_run(input int d, input int exp, input string tag);
        int n = 0;
        int w = 0;
        while (!busy[d] && w < 400) begin
            @(negedge clk);
            w++;
        end
        while (busy[d] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, exp);
    endtask

    function automatic logic [FB-1:0] rand_frame();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst_n = 1'b0;
        cts   = 1'b1;
        dat   = '0;
        bus_idle();
        cycles(3);
        for (int d = 0; d < 2; d++) begin
            chk("rst_txd",   txd[d],   4'hF);
            chk("rst_empty", empty[d], 1'b1);
            chk("rst_level", lvl[d],   '0);
            chk("rst_busy",  busy[d],  1'b0);
        end
        rst_n = 1'b1;
        cycles(2);

        // Single frame: nibbles 0..F then F..0 on the wire.
        fork
            wb_write(128'h0123456789ABCDEF_FEDCBA9876543210);
            busy_run(0, 32, "t2_busy0");
            busy_run(1, 96, "t2_busy1");
        join
        cycles(5);

        // Back-to-back frames go out gapless.
        fork
            begin
                wb_write(rand_frame());
                wb_write(rand_frame());
                wb_write(rand_frame());
            end
            busy_run(0, 96,  "t3_busy0");
            busy_run(1, 288, "t3_busy1");
        join
        cycles(5);

        // cts drop mid-frame: current frame finishes, next frame waits.
        wb_write(rand_frame());
        wb_write(rand_frame());
        cycles(8);
        cts = 1'b0;
        cycles(300);
        chk("t5_hold_txd0", txd[0], 4'hF);
        chk("t5_level0",    lvl[0], 1);
        chk("t5_level1",    lvl[1], 1);
        cts = 1'b1;
        cycles(300);

        // Fill to full with cts low, ninth write stalls until a pop.
        cts = 1'b0;
        repeat (8) wb_write(rand_frame());
        chk("t4_level0", lvl[0],  8);
        chk("t4_full0",  full[0], 1'b1);
        chk("t4_full1",  full[1], 1'b1);
        fork
            wb_write(rand_frame());
            begin
                cycles(20);
                #2;
                chk("t4_stall_ack0", ack[0], 1'b0);
                chk("t4_stall_ack1", ack[1], 1'b0);
                cts = 1'b1;
            end
        join
        cycles(50);

        // Reset in the middle of a frame with frames still queued.
        rst_n = 1'b0;
        cycles(2);
        chk("t1_txd0",   txd[0],   4'hF);
        chk("t1_sync0",  sync[0],  1'b0);
        chk("t1_empty0", empty[0], 1'b1);
        chk("t1_level1", lvl[1],   '0);
        chk("t1_busy1",  busy[1],  1'b0);
        rst_n = 1'b1;
        cycles(3);

        // Random bus traffic, reads and writes, with cts toggling.
        repeat (600) begin
            @(negedge clk);
            cs  = 2'($urandom | $urandom);
            cyc = 2'($urandom | $urandom);
            stb = 2'($urandom);
            we  = 2'($urandom | $urandom);
            dat = rand_frame();
            if ($urandom_range(0, 15) == 0) cts = ~cts;
        end
        @(negedge clk);
        bus_idle();
        cts = 1'b1;
        cycles(1000);
        chk("drain_empty0", empty[0], 1'b1);
        chk("drain_empty1", empty[1], 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
